serv_bus_arbiter: RTL and testbench

Shares a single Wishbone memory port between the SERV core's instruction bus and data bus. Holds a grant for the full transaction, gives the data bus fixed priority, and bounds instruction-fetch starvation. A watchdog terminates hung transactions so a missing slave cannot deadlock the core. Sits between `serv_top` and the SoC memory or interconnect.

---
 rtl/serv_bus_arbiter_pkg.sv | 19 +
 rtl/serv_arb_watchdog.sv | 27 ++
 rtl/serv_bus_arbiter.sv | 94 +++++++++
 tb/tb_serv_bus_arbiter.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/serv_bus_arbiter_pkg.sv
// serv_bus_arbiter_pkg: shared state encoding, widths and helpers for the SERV bus arbiter
package serv_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_IBUS = 2'd1,
        ARB_DBUS = 2'd2
    } arb_state_e;

    localparam int STARVE_W = 4;

    function automatic logic [STARVE_W-1:0] starve_inc(
        input logic [STARVE_W-1:0] cnt,
        input logic [STARVE_W-1:0] max
    );
        return (cnt >= max) ? cnt : cnt + 1'b1;
    endfunction

endpackage

// File: rtl/serv_arb_watchdog.sv
// serv_arb_watchdog: counts owned cycles without ack and fires once the limit is reached
module serv_arb_watchdog #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic i_rst_n,
    input  logic i_start,
    input  logic i_ack,
    output logic o_fire
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [CW-1:0] cnt_q, cnt_d;

    // held at zero while waiting for a grant so the first owned cycle reads zero
    always_comb cnt_d = i_start ? '0 : (i_ack ? cnt_q : cnt_q + 1'b1);

    // cycle counter register
    always_ff @(posedge clk or negedge i_rst_n)
        if (!i_rst_n) cnt_q <= '0;
        else          cnt_q <= cnt_d;

    // fire in the TIMEOUT-th owned cycle unless the slave answers in that same cycle
    always_comb o_fire = (TIMEOUT != 0) && !i_start && !i_ack && (cnt_q == CW'(TIMEOUT - 1));

endmodule

// File: rtl/serv_bus_arbiter.sv
// serv_bus_arbiter: shares one Wishbone port between SERV ibus and dbus with dbus priority and bounded ibus starvation
module serv_bus_arbiter
    import serv_bus_arbiter_pkg::*;
#(
    parameter int TIMEOUT    = 255,
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        i_rst_n,
    input  logic [31:0] i_ibus_adr,
    input  logic        i_ibus_cyc,
    output logic [31:0] o_ibus_rdt,
    output logic        o_ibus_ack,
    input  logic [31:0] i_dbus_adr,
    input  logic [31:0] i_dbus_dat,
    input  logic [3:0]  i_dbus_sel,
    input  logic        i_dbus_we,
    input  logic        i_dbus_cyc,
    output logic [31:0] o_dbus_rdt,
    output logic        o_dbus_ack,
    output logic [31:0] o_wb_adr,
    output logic [31:0] o_wb_dat,
    output logic [3:0]  o_wb_sel,
    output logic        o_wb_we,
    output logic        o_wb_cyc,
    input  logic [31:0] i_wb_rdt,
    input  logic        i_wb_ack,
    output logic        o_timeout,
    output logic        o_owner
);

    localparam logic [STARVE_W-1:0] SMAX = STARVE_W'(STARVE_MAX);

    arb_state_e          state_q, state_d;
    logic [STARVE_W-1:0] starve_q, starve_d;
    logic                in_i, in_d, owner_cyc, wd_fire, fire, ack;

    serv_arb_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
        .clk     (clk),
        .i_rst_n (i_rst_n),
        .i_start (state_q == ARB_IDLE),
        .i_ack   (i_wb_ack),
        .o_fire  (wd_fire)
    );

    // decode ownership; an owner dropping cyc aborts and suppresses any ack or forced ack
    always_comb begin
        in_i      = state_q == ARB_IBUS;
        in_d      = state_q == ARB_DBUS;
        owner_cyc = (in_i & i_ibus_cyc) | (in_d & i_dbus_cyc);
        fire      = owner_cyc & wd_fire;
        ack       = owner_cyc & (i_wb_ack | wd_fire);
    end

    // state register
    always_ff @(posedge clk or negedge i_rst_n)
        if (!i_rst_n) state_q <= ARB_IDLE;
        else          state_q <= state_d;

    // dbus wins contention unless ibus has already lost STARVE_MAX times; any end of ownership returns to idle
    always_comb
        state_d = (state_q == ARB_IDLE)
                ? ((i_dbus_cyc && !(i_ibus_cyc && starve_q == SMAX)) ? ARB_DBUS
                  : i_ibus_cyc ? ARB_IBUS : ARB_IDLE)
                : ((!owner_cyc || ack) ? ARB_IDLE : state_q);

    // count contested dbus grants, clear on every ibus grant
    always_comb
        starve_d = (state_q != ARB_IDLE)                    ? starve_q
                 : (state_d == ARB_IBUS)                    ? '0
                 : (state_d == ARB_DBUS && i_ibus_cyc)      ? starve_inc(starve_q, SMAX)
                 : starve_q;

    // starvation counter register
    always_ff @(posedge clk or negedge i_rst_n)
        if (!i_rst_n) starve_q <= '0;
        else          starve_q <= starve_d;

    // shared port mux and response routing; everything reads zero while idle
    always_comb begin
        o_wb_adr   = in_d ? i_dbus_adr : (in_i ? i_ibus_adr : '0);
        o_wb_dat   = in_d ? i_dbus_dat : '0;
        o_wb_sel   = in_d ? i_dbus_sel : (in_i ? 4'hF : 4'h0);
        o_wb_we    = in_d & i_dbus_we;
        o_wb_cyc   = owner_cyc & ~fire;
        o_owner    = in_d;
        o_ibus_ack = in_i & ack;
        o_dbus_ack = in_d & ack;
        o_ibus_rdt = (in_i && !fire) ? i_wb_rdt : '0;
        o_dbus_rdt = (in_d && !fire) ? i_wb_rdt : '0;
        o_timeout  = fire;
    end

endmodule

// File: tb/tb_serv_bus_arbiter.sv
// tb_serv_bus_arbiter: vector table, corner sequences and randomized model check of serv_bus_arbiter
module tb_serv_bus_arbiter;

    localparam int TO = 8;
    localparam int SM = 4;

    logic        clk = 1'b0, i_rst_n = 1'b0;
    logic [31:0] i_ibus_adr = '0, i_dbus_adr = '0, i_dbus_dat = '0, i_wb_rdt = '0;
    logic [3:0]  i_dbus_sel = '0;
    logic        i_ibus_cyc = 1'b0, i_dbus_cyc = 1'b0, i_dbus_we = 1'b0, i_wb_ack = 1'b0;
    logic [31:0] o_ibus_rdt, o_dbus_rdt, o_wb_adr, o_wb_dat;
    logic [3:0]  o_wb_sel;
    logic        o_ibus_ack, o_dbus_ack, o_wb_we, o_wb_cyc, o_timeout, o_owner;

    int tests = 0, fails = 0;

    always #5 clk = ~clk;

    serv_bus_arbiter #(.TIMEOUT(TO), .STARVE_MAX(SM)) dut (
        .clk(clk), .i_rst_n(i_rst_n),
        .i_ibus_adr(i_ibus_adr), .i_ibus_cyc(i_ibus_cyc), .o_ibus_rdt(o_ibus_rdt), .o_ibus_ack(o_ibus_ack),
        .i_dbus_adr(i_dbus_adr), .i_dbus_dat(i_dbus_dat), .i_dbus_sel(i_dbus_sel), .i_dbus_we(i_dbus_we),
        .i_dbus_cyc(i_dbus_cyc), .o_dbus_rdt(o_dbus_rdt), .o_dbus_ack(o_dbus_ack),
        .o_wb_adr(o_wb_adr), .o_wb_dat(o_wb_dat), .o_wb_sel(o_wb_sel), .o_wb_we(o_wb_we), .o_wb_cyc(o_wb_cyc),
        .i_wb_rdt(i_wb_rdt), .i_wb_ack(i_wb_ack), .o_timeout(o_timeout), .o_owner(o_owner)
    );

    logic any_out;
    assign any_out = |{o_ibus_rdt, o_ibus_ack, o_dbus_rdt, o_dbus_ack, o_wb_adr, o_wb_dat,
                       o_wb_sel, o_wb_we, o_wb_cyc, o_timeout, o_owner};

    typedef struct {
        bit ir, dr, we;
        int ack_at;
        logic [31:0] rdt;
        bit eo;
        int ecyc;
        bit eto;
        logic [31:0] erdt;
    } vec_t;

    vec_t tbl[16];

    bit          obs_idle, obs_owner, obs_hold, obs_ackown, obs_both, obs_to, obs_wbcyc, obs_we;
    int          obs_ackcyc;
    logic [31:0] obs_adr, obs_dat, obs_rdt, obs_orth;
    logic [3:0]  obs_sel;
    int          sv = 0;

    task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
        tests++;
        if (a !== e) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", n, a, e);
        end
    endtask

    // one transaction starting in an idle cycle at posedge+1; slave acks in owned cycle ack_at (0 = never)
    task automatic run(input bit ir, input bit dr, input bit we, input int ack_at, input logic [31:0] rdt);
        i_ibus_cyc = ir; i_dbus_cyc = dr; i_dbus_we = we; i_wb_ack = 1'b0; i_wb_rdt = rdt;
        i_ibus_adr = $urandom; i_dbus_adr = $urandom; i_dbus_dat = $urandom; i_dbus_sel = 4'($urandom);
        @(negedge clk);
        obs_idle = !o_wb_cyc && !o_ibus_ack && !o_dbus_ack && !o_timeout;
        obs_ackcyc = 0; obs_hold = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            i_wb_ack = (k == ack_at);
            @(negedge clk);
            if (k == 1) begin
                obs_owner = o_owner; obs_adr = o_wb_adr; obs_dat = o_wb_dat;
                obs_sel = o_wb_sel; obs_we = o_wb_we;
            end
            if (o_ibus_ack || o_dbus_ack) begin
                obs_ackcyc = k; obs_ackown = o_dbus_ack; obs_both = o_ibus_ack && o_dbus_ack;
                obs_to = o_timeout; obs_wbcyc = o_wb_cyc;
                obs_rdt  = o_dbus_ack ? o_dbus_rdt : o_ibus_rdt;
                obs_orth = o_dbus_ack ? o_ibus_rdt : o_dbus_rdt;
                break;
            end
            obs_hold &= o_wb_cyc;
        end
        @(posedge clk); #1;
        i_wb_ack = 1'b0;
    endtask

    task automatic verify(input string t, input bit eo, input int ecyc, input bit eto, input logic [31:0] erdt);
        chk({t, ".idle"},   obs_idle, 1);
        chk({t, ".owner"},  obs_owner, eo);
        chk({t, ".adr"},    obs_adr, eo ? i_dbus_adr : i_ibus_adr);
        chk({t, ".dat"},    obs_dat, eo ? i_dbus_dat : 32'h0);
        chk({t, ".sel"},    obs_sel, eo ? i_dbus_sel : 4'hF);
        chk({t, ".we"},     obs_we, eo ? i_dbus_we : 1'b0);
        chk({t, ".hold"},   obs_hold, 1);
        chk({t, ".ackcyc"}, obs_ackcyc, ecyc);
        chk({t, ".ackown"}, obs_ackown, eo);
        chk({t, ".both"},   obs_both, 0);
        chk({t, ".to"},     obs_to, eto);
        chk({t, ".wbcyc"},  obs_wbcyc, !eto);
        chk({t, ".rdt"},    obs_rdt, erdt);
        chk({t, ".orth"},   obs_orth, 32'h0);
    endtask

    initial begin
        tbl[0] = '{1'b1, 1'b0, 1'b0, 4, 32'h0000_0013, 1'b0, 4, 1'b0, 32'h0000_0013};
        tbl[1] = '{1'b1, 1'b1, 1'b1, 2, 32'hA5A5_0001, 1'b1, 2, 1'b0, 32'hA5A5_0001};
        tbl[2] = '{1'b0, 1'b1, 1'b0, 1, 32'h1234_5678, 1'b1, 1, 1'b0, 32'h1234_5678};
        tbl[3] = '{1'b1, 1'b0, 1'b0, 0, 32'hFFFF_0000, 1'b0, 8, 1'b1, 32'h0};
        tbl[4] = '{1'b0, 1'b1, 1'b1, 8, 32'hCAFE_0008, 1'b1, 8, 1'b0, 32'hCAFE_0008};
        tbl[5] = '{1'b0, 1'b1, 1'b0, 9, 32'h0BAD_0009, 1'b1, 8, 1'b1, 32'h0};
        for (int k = 6; k < 16; k++)
            tbl[k] = '{1'b1, 1'b1, 1'b0, 1, 32'(k), !(k == 10 || k == 15), 1, 1'b0, 32'(k)};

        i_dbus_cyc = 1'b1; i_wb_rdt = 32'hFFFF_FFFF; i_wb_ack = 1'b1;
        #12;
        chk("reset.outputs", any_out, 0);
        @(posedge clk); #1;
        i_rst_n = 1'b1; i_dbus_cyc = 1'b0; i_wb_ack = 1'b0;

        for (int i = 0; i < 16; i++) begin
            run(tbl[i].ir, tbl[i].dr, tbl[i].we, tbl[i].ack_at, tbl[i].rdt);
            verify($sformatf("tbl%0d", i), tbl[i].eo, tbl[i].ecyc, tbl[i].eto, tbl[i].erdt);
        end

        i_ibus_cyc = 1'b0; i_dbus_cyc = 1'b1; i_wb_ack = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        i_dbus_cyc = 1'b0;
        @(negedge clk);
        chk("abort.drop", {o_wb_cyc, o_ibus_ack, o_dbus_ack, o_timeout}, 0);
        @(posedge clk); #1;
        i_wb_ack = 1'b1;
        @(negedge clk);
        chk("abort.late_ack", {o_wb_cyc, o_ibus_ack, o_dbus_ack, o_timeout}, 0);
        @(posedge clk); #1;
        i_wb_ack = 1'b0;
        run(1'b1, 1'b0, 1'b0, 1, 32'h0000_0A0A);
        verify("abort.after", 1'b0, 1, 1'b0, 32'h0000_0A0A);

        i_ibus_cyc = 1'b0; i_dbus_cyc = 1'b1; i_dbus_we = 1'b1; i_wb_rdt = 32'h5555_AAAA;
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst.pre_grant", {o_wb_cyc, o_owner}, 2'b11);
        #2;
        i_rst_n = 1'b0; i_wb_ack = 1'b1;
        #1;
        chk("rst.async", any_out, 0);
        @(posedge clk); #1;
        chk("rst.held", any_out, 0);
        i_rst_n = 1'b1; i_dbus_cyc = 1'b0; i_wb_ack = 1'b0; sv = 0;
        run(1'b1, 1'b0, 1'b0, 2, 32'h0000_0013);
        verify("rst.after", 1'b0, 2, 1'b0, 32'h0000_0013);

        for (int n = 0; n < 60; n++) begin
            int r, a;
            bit ir, dr, eo, eto;
            logic [31:0] d;
            r = $urandom_range(1, 3); a = $urandom_range(0, 11); d = $urandom | 32'h1;
            ir = r[0]; dr = r[1];
            if (!ir)      eo = 1'b1;
            else if (!dr) eo = 1'b0;
            else          eo = (sv < SM);
            if (!eo)      sv = 0;
            else if (ir)  sv = (sv + 1 > SM) ? SM : sv + 1;
            eto = !(a >= 1 && a <= TO);
            run(ir, dr, 1'($urandom), a, d);
            verify($sformatf("rnd%0d", n), eo, eto ? TO : a, eto, eto ? 32'h0 : d);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
